// File: rtl/instr_fetch.sv
// instr_fetch: single-outstanding instruction fetch FSM with redirect and decode handshake
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  input  logic        out_ready
);
  typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD, DRAIN} state_t;
  state_t state, state_n;
  logic [31:0] pc;
  assign imem_req_valid = state == REQ;
  assign imem_req_addr  = pc;
  assign out_valid      = state == HOLD;
  // next state: a redirect sends any in-flight response to DRAIN so it is never delivered
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = REQ;
      REQ:     state_n = imem_req_ready ? (redirect_valid ? DRAIN : WAIT) : REQ;
      WAIT:    state_n = imem_resp_valid ? (redirect_valid ? REQ : HOLD) : (redirect_valid ? DRAIN : WAIT);
      HOLD:    state_n = (redirect_valid || out_ready) ? REQ : HOLD;
      DRAIN:   state_n = imem_resp_valid ? REQ : DRAIN;
      default: state_n = IDLE;
    endcase
  end
  // state, pc and captured instruction; redirect outranks a response landing the same cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      pc        <= RESET_PC;
      out_instr <= '0;
      out_pc    <= '0;
    end else begin
      state <= state_n;
      if (redirect_valid)
        pc <= redirect_pc & ~32'h3;
      else if (state == WAIT && imem_resp_valid) begin
        out_instr <= imem_resp_data;
        out_pc    <= pc;
        pc        <= pc + 32'd4;
      end
    end
  end
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: scoreboard bench with a latency-configurable memory model
module tb_instr_fetch;
  logic clk = 0;
  logic rst = 1;
  logic imem_req_valid, imem_req_ready = 0, imem_resp_valid = 0;
  logic [31:0] imem_req_addr, imem_resp_data = '0;
  logic redirect_valid = 0, out_valid, out_ready = 0;
  logic [31:0] redirect_pc = '0, out_instr, out_pc;
  int errors = 0, checks = 0;
  logic [31:0] exp_req[$];
  logic [63:0] exp_out[$];
  logic pend = 0, acc, rsp;
  logic [31:0] paddr = '0, acc_addr;
  int cnt = 0, lat = 0;

  instr_fetch dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr), .imem_req_ready(imem_req_ready),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_instr(out_instr), .out_pc(out_pc), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return a == 32'h0 ? 32'h0050_0093 : a == 32'h4 ? 32'h00A0_0113 : a ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    acc = imem_req_valid && imem_req_ready;
    acc_addr = imem_req_addr;
    rsp = imem_resp_valid;
    @(posedge clk);
    #2;
    if (rsp) pend = 0;
    else if (pend && cnt > 0) cnt--;
    if (acc) begin
      pend = 1;
      cnt = lat;
      paddr = acc_addr;
    end
    imem_resp_valid = pend && cnt == 0;
    imem_resp_data = imem_resp_valid ? mem(paddr) : 32'hDEAD_BEEF;
  endtask

  task automatic push_fetch(input logic [31:0] a, input logic deliver);
    exp_req.push_back(a);
    if (deliver) exp_out.push_back({a, mem(a)});
  endtask

  always @(negedge clk) begin
    if (imem_req_valid && imem_req_ready) begin
      if (exp_req.size() == 0) begin
        checks++; errors++;
        $display("FAIL req_unexpected: addr %h with none expected", imem_req_addr);
      end else chk("req_addr", imem_req_addr, exp_req.pop_front());
    end
    if (out_valid && out_ready) begin
      if (exp_out.size() == 0) begin
        checks++; errors++;
        $display("FAIL out_unexpected: pc %h instr %h with none expected", out_pc, out_instr);
      end else begin
        logic [63:0] e;
        e = exp_out.pop_front();
        chk("out_pc", out_pc, e[63:32]);
        chk("out_instr", out_instr, e[31:0]);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) cyc();
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
    chk("rst_out_pc", out_pc, 32'h0);
    chk("rst_out_instr", out_instr, 32'h0);
    rst = 0;
    chk("idle_no_req", {31'd0, imem_req_valid}, 32'd0);
    cyc();
    chk("first_req_valid", {31'd0, imem_req_valid}, 32'd1);
    chk("first_req_addr", imem_req_addr, 32'h0);
    imem_req_ready = 1;
    out_ready = 1;
    push_fetch(32'h0, 1);
    push_fetch(32'h4, 1);
    push_fetch(32'h8, 1);
    repeat (6) cyc();
    imem_req_ready = 0;
    for (int i = 0; i < 3; i++) begin
      chk("stall_req_valid", {31'd0, imem_req_valid}, 32'd1);
      chk("stall_req_addr", imem_req_addr, 32'h8);
      cyc();
    end
    imem_req_ready = 1;
    out_ready = 0;
    repeat (2) cyc();
    for (int i = 0; i < 4; i++) begin
      chk("hold_out_valid", {31'd0, out_valid}, 32'd1);
      chk("hold_out_pc", out_pc, 32'h8);
      chk("hold_out_instr", out_instr, mem(32'h8));
      chk("hold_no_req", {31'd0, imem_req_valid}, 32'd0);
      cyc();
    end
    out_ready = 1;
    lat = 2;
    push_fetch(32'hC, 0);
    cyc();
    cyc();
    redirect_valid = 1;
    redirect_pc = 32'h103;
    cyc();
    redirect_valid = 0;
    chk("drain_no_req", {31'd0, imem_req_valid}, 32'd0);
    chk("drain_no_out", {31'd0, out_valid}, 32'd0);
    cyc();
    chk("drain_resp_no_out", {31'd0, out_valid}, 32'd0);
    cyc();
    chk("redir_req_valid", {31'd0, imem_req_valid}, 32'd1);
    chk("redir_req_addr", imem_req_addr, 32'h100);
    chk("redir_no_stale", {31'd0, out_valid}, 32'd0);
    lat = 0;
    push_fetch(32'h100, 1);
    repeat (3) cyc();
    imem_req_ready = 0;
    redirect_valid = 1;
    redirect_pc = 32'hFFFF_FFFC;
    cyc();
    redirect_valid = 0;
    imem_req_ready = 1;
    chk("wrap_req_addr", imem_req_addr, 32'hFFFF_FFFC);
    push_fetch(32'hFFFF_FFFC, 1);
    push_fetch(32'h0, 0);
    repeat (3) cyc();
    chk("wrap_next_addr", imem_req_addr, 32'h0);
    out_ready = 0;
    repeat (2) cyc();
    chk("pre_rst_hold", {31'd0, out_valid}, 32'd1);
    rst = 1;
    redirect_valid = 1;
    redirect_pc = 32'h40;
    cyc();
    rst = 0;
    redirect_valid = 0;
    chk("hold_rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("hold_rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
    chk("hold_rst_out_pc", out_pc, 32'h0);
    cyc();
    chk("post_rst_req_valid", {31'd0, imem_req_valid}, 32'd1);
    chk("post_rst_req_addr", imem_req_addr, 32'h0);
    out_ready = 1;
    push_fetch(32'h0, 1);
    repeat (3) cyc();
    imem_req_ready = 0;
    repeat (2) cyc();
    chk("req_queue_empty", exp_req.size(), 32'd0);
    chk("out_queue_empty", exp_out.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL be the first fetch address after reset.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst  input  1  SHALL be the reset: synchronous, active-high.
REQ-004 imem_req_valid  output  1  SHALL flag a valid instruction-memory read request.
REQ-005 imem_req_addr  output  32  SHALL carry the request byte address (current pc).
REQ-006 imem_req_ready  input  1  SHALL mean memory accepts the request this cycle.
REQ-007 imem_resp_valid  input  1  SHALL mean imem_resp_data holds the read result this cycle.
REQ-008 imem_resp_data  input  32  SHALL carry the fetched instruction word.
REQ-009 redirect_valid  input  1  SHALL request a pc change (branch/jump taken) this cycle.
REQ-010 redirect_pc  input  32  SHALL carry the redirect target.
REQ-011 out_valid  output  1  SHALL flag a valid instruction for the decode stage.
REQ-012 out_instr  output  32  SHALL carry the fetched instruction word.
REQ-013 out_pc  output  32  SHALL carry the address out_instr was fetched from.
REQ-014 out_ready  input  1  SHALL mean the decode stage consumes out_instr this cycle.

Function
REQ-015 FSM states SHALL be IDLE, REQ, WAIT, HOLD, DRAIN; at most one memory request outstanding.
REQ-016 IDLE: no request; next state REQ unconditionally.
REQ-017 REQ: imem_req_valid=1, imem_req_addr=pc; on imem_req_ready go WAIT, else stay with addr held stable.
REQ-018 WAIT: on imem_resp_valid load out_instr<=imem_resp_data, out_pc<=pc, out_valid<=1, pc<=pc+4, go HOLD.
REQ-019 HOLD: out_valid=1, out_instr/out_pc stable; on out_ready clear out_valid, go REQ (request issued next cycle).
REQ-020 imem_req_valid SHALL be 1 only in REQ; out_valid SHALL be 1 only in HOLD.
REQ-021 pc+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-022 redirect_valid SHALL take priority over every other event: pc<=redirect_pc with bits[1:0] forced to 00, out_valid<=0.
REQ-023 Redirect next state: IDLE->REQ; REQ without imem_req_ready->REQ; REQ with imem_req_ready->DRAIN; WAIT without imem_resp_valid->DRAIN; WAIT with imem_resp_valid->REQ (response discarded, pc not incremented); HOLD->REQ (held instruction dropped even if out_ready=1); DRAIN->DRAIN, or REQ if imem_resp_valid same cycle.
REQ-024 DRAIN: no request issued; on imem_resp_valid discard data, go REQ; pc unchanged.
REQ-025 imem_resp_valid outside WAIT/DRAIN SHALL be ignored.
REQ-026 Latency: request-accept to out_valid SHALL be 1 cycle after imem_resp_valid; fetch-to-fetch minimum 3 cycles with zero-wait memory and out_ready=1.

Reset
REQ-027 While rst=1: state<=IDLE, pc<=RESET_PC, out_valid<=0, out_instr<=0, out_pc<=0; rst overrides redirect_valid.
REQ-028 Reset asserted mid-transaction SHALL abandon any outstanding request; responses arriving in IDLE are ignored.
REQ-029 First request SHALL appear 2 cycles after rst deasserts (IDLE then REQ), addr RESET_PC.

Verification
REQ-030 Zero-wait memory, out_ready=1, words 0x00500093,0x00A00113 -> out_pc 0x0,0x4 with matching out_instr, one out_valid pulse each.
REQ-031 imem_req_ready low 3 cycles -> imem_req_valid=1, imem_req_addr stable at 0x8 throughout; no pc advance.
REQ-032 out_ready low 4 cycles in HOLD -> out_valid, out_instr, out_pc stable; no new request until consumed.
REQ-033 Redirect to 0x103 while in WAIT -> next response discarded, next request addr 0x100, out_valid never 1 for stale word.
REQ-034 pc=0xFFFFFFFC fetch completes -> next request addr 0x00000000.
REQ-035 rst pulsed while in HOLD with redirect_valid=1 -> out_valid=0, next request addr RESET_PC.
